// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin arbiter sharing one single-port RAM between two Avalon-MM masters.
// Define ONCHIP_ARB_LOCK_EN to let port 1 hold the grant across consecutive accesses via p1_lock.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                reset_req,
    input  logic [ADDR_W-1:0]   p0_address,
    input  logic [DATA_W/8-1:0] p0_byteenable,
    input  logic                p0_read,
    input  logic                p0_write,
    input  logic [DATA_W-1:0]   p0_writedata,
    output logic                p0_waitrequest,
    output logic                p0_readdatavalid,
    output logic [DATA_W-1:0]   p0_readdata,
    input  logic [ADDR_W-1:0]   p1_address,
    input  logic [DATA_W/8-1:0] p1_byteenable,
    input  logic                p1_read,
    input  logic                p1_write,
    input  logic [DATA_W-1:0]   p1_writedata,
    input  logic                p1_lock,
    output logic                p1_waitrequest,
    output logic                p1_readdatavalid,
    output logic [DATA_W-1:0]   p1_readdata,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);
    logic                w_req0;
    logic                w_req1;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_p1_pri;
    logic                r_last;
    logic [1:0]          r_rd_pend;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W/8-1:0] r_be;

`ifdef ONCHIP_ARB_LOCK_EN
    logic r_locked;
    assign w_p1_pri = r_locked | ~r_last;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_locked <= 1'b0;
        else          r_locked <= p1_lock & (r_locked | w_gnt1);
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = p1_lock;
    assign w_p1_pri      = ~r_last;
`endif

    assign w_req0 = p0_read | p0_write;
    assign w_req1 = p1_read | p1_write;
    assign w_gnt0 = ~reset_req & w_req0 & (~w_req1 | ~w_p1_pri);
    assign w_gnt1 = ~reset_req & w_req1 & ~w_gnt0;

    assign p0_waitrequest   = w_req0 & ~w_gnt0;
    assign p1_waitrequest   = w_req1 & ~w_gnt1;
    assign p0_readdatavalid = r_rd_pend[0];
    assign p1_readdatavalid = r_rd_pend[1];
    assign p0_readdata      = mem_readdata;
    assign p1_readdata      = mem_readdata;

    // Address and byte lanes park on the last granted value when idle
    always_comb begin
        mem_address    = w_gnt0 ? p0_address    : w_gnt1 ? p1_address    : r_addr;
        mem_byteenable = w_gnt0 ? p0_byteenable : w_gnt1 ? p1_byteenable : r_be;
        mem_writedata  = w_gnt1 ? p1_writedata  : p0_writedata;
        mem_write      = (w_gnt0 & p0_write) | (w_gnt1 & p1_write);
        mem_chipselect = w_gnt0 | w_gnt1;
        mem_clken      = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last    <= 1'b1;
            r_rd_pend <= 2'b00;
            r_addr    <= '0;
            r_be      <= '0;
        end else begin
            r_last    <= w_gnt0 ? 1'b0 : w_gnt1 ? 1'b1 : r_last;
            r_rd_pend <= {w_gnt1 & ~p1_write, w_gnt0 & ~p0_write};
            r_addr    <= mem_address;
            r_be      <= mem_byteenable;
        end
    end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed-vector bench for onchip_mem_arbiter with a behavioural 1024x32 RAM.
module tb_onchip_mem_arbiter;
`ifdef ONCHIP_ARB_LOCK_EN
    localparam logic LOCK = 1'b1;
`else
    localparam logic LOCK = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_n, reset_req;
    logic [9:0]  p0_address, p1_address, mem_address;
    logic [3:0]  p0_byteenable, p1_byteenable, mem_byteenable;
    logic        p0_read, p0_write, p1_read, p1_write, p1_lock;
    logic [31:0] p0_writedata, p1_writedata, p0_readdata, p1_readdata;
    logic        p0_waitrequest, p1_waitrequest, p0_readdatavalid, p1_readdatavalid;
    logic [31:0] mem_writedata, mem_readdata;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] ram [1024];
    int          n_tests = 0;
    int          n_fail = 0;
    int          c0, c1;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
        .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
        .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_waitrequest(p0_waitrequest),
        .p0_readdatavalid(p0_readdatavalid), .p0_readdata(p0_readdata),
        .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
        .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_lock(p1_lock),
        .p1_waitrequest(p1_waitrequest), .p1_readdatavalid(p1_readdatavalid),
        .p1_readdata(p1_readdata), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 0; reset_req = 0; p1_lock = 0;
        p0_address = 0; p0_byteenable = 4'hF; p0_read = 0; p0_write = 0; p0_writedata = 0;
        p1_address = 0; p1_byteenable = 4'hF; p1_read = 0; p1_write = 0; p1_writedata = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[10'h005] = 32'hDEADBEEF;
        ram[10'h010] = 32'h1000_0010;
        ram[10'h020] = 32'h2000_0020;
        ram[10'h3FF] = 32'hAAAA_BBBB;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        #3;
        check("rst_wait0", p0_waitrequest, 0);
        check("rst_wait1", p1_waitrequest, 0);
        check("rst_cs", mem_chipselect, 0);
        check("rst_wr", mem_write, 0);
        check("rst_rdv0", p0_readdatavalid, 0);
        check("rst_rdv1", p1_readdatavalid, 0);
        check("clken", mem_clken, 1);

        p0_address = 10'h005; p0_read = 1;
        #3;
        check("rd0_wait", p0_waitrequest, 0);
        check("rd0_cs", mem_chipselect, 1);
        check("rd0_addr", mem_address, 10'h005);
        tick();
        p0_read = 0;
        check("rd0_rdv", p0_readdatavalid, 1);
        check("rd0_data", p0_readdata, 32'hDEADBEEF);
        check("rd0_rdv1", p1_readdatavalid, 0);

        p1_address = 10'h005; p1_read = 1;
        #3;
        check("rd1_wait", p1_waitrequest, 0);
        tick();
        p1_read = 0;
        check("rd1_rdv", p1_readdatavalid, 1);
        check("rd1_data", p1_readdata, 32'hDEADBEEF);

        p0_address = 10'h010; p1_address = 10'h020; p0_read = 1; p1_read = 1;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 6; i++) begin
            #3;
            check("rr_wait0", p0_waitrequest, (i % 2 == 1));
            check("rr_wait1", p1_waitrequest, (i % 2 == 0));
            check("rr_addr", mem_address, (i % 2 == 1) ? 10'h020 : 10'h010);
            tick();
            check("rr_rdv0", p0_readdatavalid, (i % 2 == 0));
            check("rr_rdv1", p1_readdatavalid, (i % 2 == 1));
            check("rr_data", p0_readdata, (i % 2 == 1) ? 32'h2000_0020 : 32'h1000_0010);
            c0 += int'(p0_readdatavalid);
            c1 += int'(p1_readdatavalid);
        end
        check("rr_cnt0", c0, 3);
        check("rr_cnt1", c1, 3);

        reset_req = 1;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("rq_wait0", p0_waitrequest, 1);
            check("rq_wait1", p1_waitrequest, 1);
            check("rq_cs", mem_chipselect, 0);
            tick();
            check("rq_rdv", {p1_readdatavalid, p0_readdatavalid}, 0);
        end
        reset_req = 0;
        #3;
        check("rq_rel_wait0", p0_waitrequest, 0);
        check("rq_rel_wait1", p1_waitrequest, 1);
        tick();
        check("rq_rel_rdv0", p0_readdatavalid, 1);
        #3;
        check("rq_nxt_wait1", p1_waitrequest, 0);
        tick();
        p0_read = 0; p1_read = 0;
        check("rq_nxt_rdv1", p1_readdatavalid, 1);

        p1_address = 10'h3FF; p1_write = 1; p1_writedata = 32'h12345678; p1_byteenable = 4'b0011;
        #3;
        check("wr1_wait", p1_waitrequest, 0);
        check("wr1_mwr", mem_write, 1);
        check("wr1_be", mem_byteenable, 4'b0011);
        tick();
        p1_write = 0; p0_address = 10'h3FF; p0_read = 1;
        #3;
        check("wr1_rd_mwr", mem_write, 0);
        tick();
        p0_read = 0;
        check("wr1_rd_rdv", p0_readdatavalid, 1);
        check("wr1_rd_data", p0_readdata, 32'hAAAA5678);
        check("wr1_rd_rdv1", p1_readdatavalid, 0);

        p0_address = 10'h030; p0_read = 1; p0_write = 1; p0_writedata = 32'hCAFEF00D; p0_byteenable = 4'hF;
        #3;
        check("rw_mwr", mem_write, 1);
        tick();
        p0_write = 0;
        check("rw_no_rdv", p0_readdatavalid, 0);
        #3;
        tick();
        p0_read = 0;
        check("rw_rd_data", p0_readdata, 32'hCAFEF00D);
        check("rw_rd_rdv", p0_readdatavalid, 1);

        p0_address = 10'h005; p0_read = 1;
        #3;
        @(posedge clk);
        reset_n = 0;
        p0_read = 0;
        #1;
        check("arst_rdv0", p0_readdatavalid, 0);
        #3;
        reset_n = 1;
        p0_address = 10'h010; p1_address = 10'h020; p0_read = 1; p1_read = 1;
        #1;
        check("arst_wait0", p0_waitrequest, 0);
        check("arst_wait1", p1_waitrequest, 1);
        tick();
        check("arst_rdv0b", p0_readdatavalid, 1);

        p1_lock = 1;
        #3;
        check("lk1_wait0", p0_waitrequest, 1);
        check("lk1_wait1", p1_waitrequest, 0);
        tick();
        p1_read = 0; p1_write = 1; p1_address = 10'h040; p1_writedata = 32'h55AA55AA; p1_byteenable = 4'hF;
        #3;
        check("lk2_wait0", p0_waitrequest, LOCK);
        check("lk2_wait1", p1_waitrequest, !LOCK);
        tick();
        p1_write = 0; p1_read = 1; p1_lock = 0;
        #3;
        check("lk3_wait0", p0_waitrequest, 1);
        check("lk3_wait1", p1_waitrequest, 0);
        tick();
        #3;
        check("lk4_wait0", p0_waitrequest, 0);
        check("lk4_wait1", p1_waitrequest, 1);
        tick();
        p0_read = 0; p1_read = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
